bictr_dcnto_monitor: RTL and testbench
======================================

Name: bictr_dcnto_monitor

Overview:
- Synthesizable passive checker on the far side of the up/down counter interface (load, cen, up_dn, data, count_to in; count, tercnt out).
- Stimulus generator drives the counter; this block reads the same pins and keeps a shadow model of the counter.
- Flags every count/tercnt mismatch, counts errors, and captures the first failure for debug.
- Sits beside the counter in benches and emulation builds; never drives the DUT.

Parameters:
- WIDTH, 8, counter data/count width.
- ERR_W, 8, error counter width (saturating).
- CYC_W, 16, cycle-stamp counter width.
- STOP_ON_ERR, 0, 1 = freeze checking after the first mismatch.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- chk_en  input  1  comparison enable; the shadow model tracks regardless.
- clr  input  1  synchronous clear of errors and capture; forces resync.
- load  input  1  observed DUT load, active-low.
- cen  input  1  observed DUT count enable, active-high.
- up_dn  input  1  observed direction, 1 = up.
- data  input  WIDTH  observed load value.
- count_to  input  WIDTH  observed terminal-count compare value.
- count  input  WIDTH  observed DUT count.
- tercnt  input  1  observed DUT terminal count.
- err  output  1  one-cycle pulse per detected mismatch.
- err_cnt  output  ERR_W  saturating mismatch count.
- first_err_valid  output  1  sticky, set when the first mismatch is captured.
- first_err_exp  output  WIDTH  expected count at the first mismatch.
- first_err_act  output  WIDTH  observed count at the first mismatch.
- first_err_cyc  output  CYC_W  cycle stamp of the first mismatch.
- halted  output  1  high in HALT.

Behaviour:
- Reset (reset=0, async): state=SYNC; shadow=0; cyc=0; err=0; err_cnt=0; first_err_valid=0; first_err_exp/act/cyc=0; halted=0.
- Model next value nxt(x):
  - load=0: nxt=data. Load has priority over cen.
  - else cen=1: nxt = up_dn ? x+1 : x-1, modulo 2^WIDTH (0xFF+1 -> 0x00; 0x00-1 -> 0xFF).
  - else: nxt=x.
- Expected tercnt = (shadow == count_to), combinational on the current cycle.
- cyc increments every clock, wrapping at 2^CYC_W, and is cleared by clr.
- FSM states:
  - SYNC:
    - shadow <= nxt(count), seeded from the observed count.
    - No comparison this cycle.
    - Next state CHECK.
  - CHECK:
    - shadow <= nxt(shadow).
    - mismatch = chk_en & ((count != shadow) | (tercnt != exp_tercnt)).
    - On mismatch, registered (1-cycle latency): err=1 next cycle; err_cnt+1, saturating at all-ones.
    - If first_err_valid=0 on that mismatch: capture exp=shadow, act=count, cyc=cyc, and set first_err_valid.
    - On mismatch with STOP_ON_ERR=1: next state HALT.
  - HALT:
    - halted=1; no comparisons; err=0.
    - Shadow frozen; counters and capture hold.
- clr=1 (any state):
  - Next cycle: err_cnt=0, first_err_valid=0, capture fields=0, cyc=0, err=0, halted=0, state=SYNC.
  - clr overrides a mismatch in the same cycle.
- chk_en=0: shadow keeps tracking; no errors raised; capture is untouched.
- Reset asserted mid-operation: immediate return to the reset values; first post-reset cycle is SYNC.

Optional Feature:
- Macro: BICTR_DCNTO_MON_COVER_EN.
- Defined:
  - Adds four saturating ERR_W-wide outputs: cov_load, cov_wrap_up (shadow 0xFF->0x00 by count), cov_wrap_dn (0x00->0xFF), cov_tercnt (exp_tercnt=1).
  - Counted only in CHECK with chk_en=1; cleared by reset and clr.
- Undefined: ports and logic are absent; the block behaves identically otherwise.

Decomposition:
- Package bictr_mon_pkg:
  - State enum {SYNC, CHECK, HALT}.
  - Function bictr_next(cur, load, cen, up_dn, data) implementing nxt().
  - Localparams for the cover-counter widths.
- One sub-module bictr_mon_capture: first-error capture registers plus saturating err_cnt, with inputs mismatch, clr, exp, act, cyc.

Test Plan:
- Reset, then clr=0, chk_en=1, cen=1, up_dn=1, load=1, count_to=0x05, with a correct DUT for 300 cycles -> err never asserted; err_cnt=0; wrap 0xFF->0x00 accepted.
- Drive load=0 with data=0xA0 and cen=1 in the same cycle, correct DUT -> shadow=0xA0 next cycle (load wins); no error.
- Force count=0x12 while shadow=0x11 at cyc=40 -> err pulses at cycle 41; err_cnt=1; first_err_exp=0x11, first_err_act=0x12, first_err_cyc=40; a second fault leaves the capture unchanged and makes err_cnt=2.
- STOP_ON_ERR=1, force a tercnt mismatch (count=count_to=0x05, tercnt=0) -> err=1 once, halted=1; later faults are ignored; pulse clr -> halted=0, SYNC then CHECK, err_cnt=0.
- Inject 300 faults with ERR_W=8 -> err_cnt saturates at 0xFF.
- Assert reset mid-run with err_cnt=3 -> all outputs return to 0 asynchronously; the first post-reset cycle raises no error even with count≠0.

Source files
------------

// File: rtl/bictr_mon_pkg.sv
// bictr_mon_pkg: shared types and helpers for the up/down counter monitor.
//   - bictr_state_e : monitor FSM states (SYNC, CHECK, HALT)
//   - bictr_next()  : reference next-count function; works on BICTR_MAX_W
//                     bits so callers of any width <= 63 can zero-extend
//                     their operands and truncate the result.
// Optional macro BICTR_DCNTO_MON_COVER_EN adds the cover-counter indices.
package bictr_mon_pkg;

  localparam int unsigned BICTR_MAX_W = 64;

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_CHECK = 2'd1,
    ST_HALT  = 2'd2
  } bictr_state_e;

`ifdef BICTR_DCNTO_MON_COVER_EN
  localparam int unsigned BICTR_COV_NUM     = 4;
  localparam int unsigned BICTR_COV_LOAD    = 0;
  localparam int unsigned BICTR_COV_WRAP_UP = 1;
  localparam int unsigned BICTR_COV_WRAP_DN = 2;
  localparam int unsigned BICTR_COV_TERCNT  = 3;
`endif

  // Load (active-low) beats count enable; counting wraps modulo the
  // caller's width once the caller truncates the result.
  function automatic logic [BICTR_MAX_W-1:0] bictr_next(
    input logic [BICTR_MAX_W-1:0] cur,
    input logic                   load,
    input logic                   cen,
    input logic                   up_dn,
    input logic [BICTR_MAX_W-1:0] data
  );
    logic [BICTR_MAX_W-1:0] nxt;
    if (!load) begin
      nxt = data;
    end else if (cen) begin
      if (up_dn) begin
        nxt = cur + BICTR_MAX_W'(1);
      end else begin
        nxt = cur - BICTR_MAX_W'(1);
      end
    end else begin
      nxt = cur;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bictr_mon_capture.sv
// bictr_mon_capture: saturating mismatch counter plus first-failure capture.
// Ports:
//   clk, reset (async active-low), clr (sync clear, wins over mismatch)
//   mismatch         : qualified mismatch strobe for this cycle
//   exp, act, cyc    : expected count, observed count, cycle stamp to capture
//   err_cnt          : saturating mismatch count
//   first_err_*      : sticky capture of the first mismatch since reset/clr
module bictr_mon_capture
  import bictr_mon_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ERR_W = 8,
  parameter int unsigned CYC_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             mismatch,
  input  logic [WIDTH-1:0] exp,
  input  logic [WIDTH-1:0] act,
  input  logic [CYC_W-1:0] cyc,
  output logic [ERR_W-1:0] err_cnt,
  output logic             first_err_valid,
  output logic [WIDTH-1:0] first_err_exp,
  output logic [WIDTH-1:0] first_err_act,
  output logic [CYC_W-1:0] first_err_cyc
);

  logic [ERR_W-1:0] err_cnt_q;
  logic             valid_q;
  logic [WIDTH-1:0] exp_q;
  logic [WIDTH-1:0] act_q;
  logic [CYC_W-1:0] cyc_q;

  // Error count saturates; capture fields latch only on the first mismatch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_cnt_q <= '0;
      valid_q   <= 1'b0;
      exp_q     <= '0;
      act_q     <= '0;
      cyc_q     <= '0;
    end else if (clr) begin
      err_cnt_q <= '0;
      valid_q   <= 1'b0;
      exp_q     <= '0;
      act_q     <= '0;
      cyc_q     <= '0;
    end else if (mismatch) begin
      if (err_cnt_q != {ERR_W{1'b1}}) begin
        err_cnt_q <= err_cnt_q + ERR_W'(1);
      end else begin
        err_cnt_q <= err_cnt_q;
      end
      if (!valid_q) begin
        valid_q <= 1'b1;
        exp_q   <= exp;
        act_q   <= act;
        cyc_q   <= cyc;
      end else begin
        valid_q <= valid_q;
      end
    end else begin
      err_cnt_q <= err_cnt_q;
    end
  end

  assign err_cnt         = err_cnt_q;
  assign first_err_valid = valid_q;
  assign first_err_exp   = exp_q;
  assign first_err_act   = act_q;
  assign first_err_cyc   = cyc_q;

endmodule

// File: rtl/bictr_dcnto_monitor.sv
// bictr_dcnto_monitor: passive checker for an up/down counter with load and
// terminal count. Keeps a shadow copy of the counter (seeded from the
// observed count in SYNC), compares count/tercnt in CHECK, pulses err one
// cycle after each mismatch and records the first failure.
// Ports: clk, reset (async active-low), chk_en, clr; observed DUT pins load
// (active-low), cen, up_dn, data, count_to, count, tercnt; outputs err,
// err_cnt, first_err_valid/exp/act/cyc, halted.
// Optional macro BICTR_DCNTO_MON_COVER_EN adds cov_load, cov_wrap_up,
// cov_wrap_dn, cov_tercnt saturating event counters.
module bictr_dcnto_monitor
  import bictr_mon_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned ERR_W       = 8,
  parameter int unsigned CYC_W       = 16,
  parameter bit          STOP_ON_ERR = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             chk_en,
  input  logic             clr,
  input  logic             load,
  input  logic             cen,
  input  logic             up_dn,
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] count_to,
  input  logic [WIDTH-1:0] count,
  input  logic             tercnt,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt,
  output logic             first_err_valid,
  output logic [WIDTH-1:0] first_err_exp,
  output logic [WIDTH-1:0] first_err_act,
  output logic [CYC_W-1:0] first_err_cyc,
  output logic             halted
`ifdef BICTR_DCNTO_MON_COVER_EN
  ,
  output logic [ERR_W-1:0] cov_load,
  output logic [ERR_W-1:0] cov_wrap_up,
  output logic [ERR_W-1:0] cov_wrap_dn,
  output logic [ERR_W-1:0] cov_tercnt
`endif
);

  bictr_state_e           state_q;
  logic [WIDTH-1:0]       shadow_q;
  logic [CYC_W-1:0]       cyc_q;
  logic                   err_q;
  logic                   halted_q;

  logic [BICTR_MAX_W-1:0] cnt_ext_d;
  logic [BICTR_MAX_W-1:0] shd_ext_d;
  logic [BICTR_MAX_W-1:0] dat_ext_d;
  logic [BICTR_MAX_W-1:0] nxt_cnt_full_d;
  logic [BICTR_MAX_W-1:0] nxt_shd_full_d;
  logic                   exp_tercnt_d;
  logic                   mismatch_d;
  logic                   unused_hi_s;

  // Next-value prediction from both the observed count and the shadow,
  // plus the qualified mismatch for this cycle.
  always_comb begin
    cnt_ext_d              = '0;
    cnt_ext_d[WIDTH-1:0]   = count;
    shd_ext_d              = '0;
    shd_ext_d[WIDTH-1:0]   = shadow_q;
    dat_ext_d              = '0;
    dat_ext_d[WIDTH-1:0]   = data;
    nxt_cnt_full_d = bictr_next(cnt_ext_d, load, cen, up_dn, dat_ext_d);
    nxt_shd_full_d = bictr_next(shd_ext_d, load, cen, up_dn, dat_ext_d);
    exp_tercnt_d   = (shadow_q == count_to);
    if (state_q == ST_CHECK) begin
      mismatch_d = chk_en & ((count != shadow_q) | (tercnt != exp_tercnt_d));
    end else begin
      mismatch_d = 1'b0;
    end
  end

  // Bits above WIDTH only matter for wide callers of the shared helper.
  assign unused_hi_s = ^{nxt_cnt_full_d[BICTR_MAX_W-1:WIDTH],
                         nxt_shd_full_d[BICTR_MAX_W-1:WIDTH]};

  // Monitor FSM with shadow counter, cycle stamp and registered err/halted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_SYNC;
      shadow_q <= '0;
      cyc_q    <= '0;
      err_q    <= 1'b0;
      halted_q <= 1'b0;
    end else if (clr) begin
      // Clear wins over any mismatch this cycle and forces a resync.
      state_q  <= ST_SYNC;
      shadow_q <= shadow_q;
      cyc_q    <= '0;
      err_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      cyc_q <= cyc_q + CYC_W'(1);
      err_q <= mismatch_d;
      case (state_q)
        ST_SYNC: begin
          shadow_q <= nxt_cnt_full_d[WIDTH-1:0];
          state_q  <= ST_CHECK;
          halted_q <= 1'b0;
        end
        ST_CHECK: begin
          shadow_q <= nxt_shd_full_d[WIDTH-1:0];
          if (mismatch_d && STOP_ON_ERR) begin
            state_q  <= ST_HALT;
            halted_q <= 1'b1;
          end else begin
            state_q  <= ST_CHECK;
            halted_q <= 1'b0;
          end
        end
        ST_HALT: begin
          shadow_q <= shadow_q;
          state_q  <= ST_HALT;
          halted_q <= 1'b1;
        end
        default: begin
          shadow_q <= shadow_q;
          state_q  <= ST_SYNC;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  bictr_mon_capture #(
    .WIDTH (WIDTH),
    .ERR_W (ERR_W),
    .CYC_W (CYC_W)
  ) u_capture (
    .clk             (clk),
    .reset           (reset),
    .clr             (clr),
    .mismatch        (mismatch_d),
    .exp             (shadow_q),
    .act             (count),
    .cyc             (cyc_q),
    .err_cnt         (err_cnt),
    .first_err_valid (first_err_valid),
    .first_err_exp   (first_err_exp),
    .first_err_act   (first_err_act),
    .first_err_cyc   (first_err_cyc)
  );

  assign err    = err_q;
  assign halted = halted_q;

`ifdef BICTR_DCNTO_MON_COVER_EN
  logic [BICTR_COV_NUM-1:0] cov_hit_d;
  logic [ERR_W-1:0]         cov_q [BICTR_COV_NUM];

  // Coverage events are only meaningful while actively checking.
  always_comb begin
    cov_hit_d = '0;
    if ((state_q == ST_CHECK) && chk_en) begin
      cov_hit_d[BICTR_COV_LOAD]    = ~load;
      cov_hit_d[BICTR_COV_WRAP_UP] = load & cen & up_dn & (shadow_q == {WIDTH{1'b1}});
      cov_hit_d[BICTR_COV_WRAP_DN] = load & cen & ~up_dn & (shadow_q == {WIDTH{1'b0}});
      cov_hit_d[BICTR_COV_TERCNT]  = exp_tercnt_d;
    end else begin
      cov_hit_d = '0;
    end
  end

  // Saturating cover counters, cleared by reset and clr.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < BICTR_COV_NUM; i++) cov_q[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < BICTR_COV_NUM; i++) cov_q[i] <= '0;
    end else begin
      for (int i = 0; i < BICTR_COV_NUM; i++) begin
        if (cov_hit_d[i] && (cov_q[i] != {ERR_W{1'b1}})) begin
          cov_q[i] <= cov_q[i] + ERR_W'(1);
        end else begin
          cov_q[i] <= cov_q[i];
        end
      end
    end
  end

  assign cov_load    = cov_q[BICTR_COV_LOAD];
  assign cov_wrap_up = cov_q[BICTR_COV_WRAP_UP];
  assign cov_wrap_dn = cov_q[BICTR_COV_WRAP_DN];
  assign cov_tercnt  = cov_q[BICTR_COV_TERCNT];
`endif

endmodule

// File: tb/tb_bictr_dcnto_monitor.sv
// Directed bench for bictr_dcnto_monitor. Two monitors watch the same pins:
// u_dut (STOP_ON_ERR=0) and u_stop (STOP_ON_ERR=1). The bench owns a
// reference counter and injects faults by XORing the presented count or
// flipping tercnt for single cycles.
module tb_bictr_dcnto_monitor;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, chk_en, clr, load, cen, up_dn, tercnt;
  logic [7:0] data, count_to, count;

  logic        a_err, a_valid, a_halted;
  logic [7:0]  a_err_cnt, a_exp, a_act;
  logic [15:0] a_cyc;
  logic        s_err, s_valid, s_halted;
  logic [7:0]  s_err_cnt, s_exp, s_act;
  logic [15:0] s_cyc;
`ifdef BICTR_DCNTO_MON_COVER_EN
  logic [7:0]  a_cov_load, a_cov_up, a_cov_dn, a_cov_ter;
  logic [7:0]  s_cov_load, s_cov_up, s_cov_dn, s_cov_ter;
`endif

  bictr_dcnto_monitor #(.WIDTH(8), .ERR_W(8), .CYC_W(16), .STOP_ON_ERR(1'b0)) u_dut (
    .clk(clk), .reset(reset), .chk_en(chk_en), .clr(clr), .load(load), .cen(cen),
    .up_dn(up_dn), .data(data), .count_to(count_to), .count(count), .tercnt(tercnt),
    .err(a_err), .err_cnt(a_err_cnt), .first_err_valid(a_valid), .first_err_exp(a_exp),
    .first_err_act(a_act), .first_err_cyc(a_cyc), .halted(a_halted)
`ifdef BICTR_DCNTO_MON_COVER_EN
    , .cov_load(a_cov_load), .cov_wrap_up(a_cov_up), .cov_wrap_dn(a_cov_dn), .cov_tercnt(a_cov_ter)
`endif
  );

  bictr_dcnto_monitor #(.WIDTH(8), .ERR_W(8), .CYC_W(16), .STOP_ON_ERR(1'b1)) u_stop (
    .clk(clk), .reset(reset), .chk_en(chk_en), .clr(clr), .load(load), .cen(cen),
    .up_dn(up_dn), .data(data), .count_to(count_to), .count(count), .tercnt(tercnt),
    .err(s_err), .err_cnt(s_err_cnt), .first_err_valid(s_valid), .first_err_exp(s_exp),
    .first_err_act(s_act), .first_err_cyc(s_cyc), .halted(s_halted)
`ifdef BICTR_DCNTO_MON_COVER_EN
    , .cov_load(s_cov_load), .cov_wrap_up(s_cov_up), .cov_wrap_dn(s_cov_dn), .cov_tercnt(s_cov_ter)
`endif
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  int         bench_cyc = 0;
  int         err_seen = 0;
  logic [7:0] ref_cnt;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] model_next(input logic [7:0] x);
    if (!load) return data;
    if (cen) return up_dn ? x + 8'd1 : x - 8'd1;
    return x;
  endfunction

  // One clock: present (possibly corrupted) pins, advance the reference
  // counter at the rising edge, return at the following falling edge.
  task automatic cycle_t(input logic [7:0] cnt_x, input logic ter_x);
    count  = ref_cnt ^ cnt_x;
    tercnt = (ref_cnt == count_to) ^ ter_x;
    @(posedge clk);
    ref_cnt = model_next(ref_cnt);
    bench_cyc++;
    @(negedge clk);
  endtask

  // Clear cycle that also loads the reference counter with seed.
  task automatic clr_t(input logic [7:0] seed);
    clr  = 1'b1;
    load = 1'b0;
    data = seed;
    cycle_t(8'h00, 1'b0);
    clr  = 1'b0;
    load = 1'b1;
    bench_cyc = 0;
  endtask

  initial begin
    reset = 1'b0; chk_en = 1'b1; clr = 1'b0; load = 1'b1; cen = 1'b1; up_dn = 1'b1;
    data = 8'h00; count_to = 8'h05; ref_cnt = 8'h00; count = 8'h00; tercnt = 1'b0;
    repeat (2) @(negedge clk);

    // Reset values
    chk_eq("rst_err", a_err, 0);
    chk_eq("rst_err_cnt", a_err_cnt, 0);
    chk_eq("rst_valid", a_valid, 0);
    chk_eq("rst_exp", a_exp, 0);
    chk_eq("rst_act", a_act, 0);
    chk_eq("rst_cyc", a_cyc, 0);
    chk_eq("rst_halted", s_halted, 0);
    reset = 1'b1;
    bench_cyc = 0;

    // 300 clean up-count cycles including 0xFF->0x00 wrap
    for (int i = 0; i < 300; i++) begin
      cycle_t(8'h00, 1'b0);
      if (a_err) err_seen++;
    end
    chk_eq("run_err_seen", err_seen, 0);
    chk_eq("run_err_cnt", a_err_cnt, 0);
    chk_eq("run_valid", a_valid, 0);

    // Load wins over cen, then hold, then down-count across 0x00->0xFF
    load = 1'b0; data = 8'hA0; cen = 1'b1;
    cycle_t(8'h00, 1'b0);
    load = 1'b1; cen = 1'b0;
    cycle_t(8'h00, 1'b0);
    cycle_t(8'h00, 1'b0);
    chk_eq("load_ref", ref_cnt, 8'hA0);
    chk_eq("load_err_cnt", a_err_cnt, 0);
    load = 1'b0; data = 8'h01;
    cycle_t(8'h00, 1'b0);
    load = 1'b1; cen = 1'b1; up_dn = 1'b0;
    for (int i = 0; i < 4; i++) cycle_t(8'h00, 1'b0);
    chk_eq("down_ref", ref_cnt, 8'hFD);
    chk_eq("down_err_cnt", a_err_cnt, 0);
    up_dn = 1'b1;

    // First-error capture at cycle 40: shadow 0x11, observed 0x12
    clr_t(8'hE9);
    while (bench_cyc < 40) cycle_t(8'h00, 1'b0);
    chk_eq("cap_pre_ref", ref_cnt, 8'h11);
    cycle_t(8'h03, 1'b0);
    chk_eq("cap_err", a_err, 1);
    chk_eq("cap_err_cnt", a_err_cnt, 1);
    chk_eq("cap_valid", a_valid, 1);
    chk_eq("cap_exp", a_exp, 8'h11);
    chk_eq("cap_act", a_act, 8'h12);
    chk_eq("cap_cyc", a_cyc, 40);
    cycle_t(8'h00, 1'b0);
    chk_eq("cap_err_pulse", a_err, 0);
    cycle_t(8'h40, 1'b0);
    chk_eq("cap2_err_cnt", a_err_cnt, 2);
    chk_eq("cap2_exp", a_exp, 8'h11);
    chk_eq("cap2_act", a_act, 8'h12);
    chk_eq("cap2_cyc", a_cyc, 40);

    // STOP_ON_ERR: tercnt mismatch with count == count_to == 0x05
    clr_t(8'h02);
    chk_eq("stop_clr_halted", s_halted, 0);
    chk_eq("stop_clr_err_cnt", s_err_cnt, 0);
    for (int i = 0; i < 3; i++) cycle_t(8'h00, 1'b0);
    chk_eq("stop_pre_ref", ref_cnt, 8'h05);
    cycle_t(8'h00, 1'b1);
    chk_eq("stop_err", s_err, 1);
    chk_eq("stop_halted", s_halted, 1);
    chk_eq("stop_err_cnt", s_err_cnt, 1);
    cycle_t(8'h0F, 1'b0);
    chk_eq("halt_err", s_err, 0);
    chk_eq("halt_halted", s_halted, 1);
    cycle_t(8'h01, 1'b1);
    chk_eq("halt_err_cnt", s_err_cnt, 1);
    clr_t(8'h30);
    chk_eq("halt_clr_halted", s_halted, 0);
    chk_eq("halt_clr_err_cnt", s_err_cnt, 0);
    chk_eq("halt_clr_valid", s_valid, 0);
    cycle_t(8'h00, 1'b0);
    cycle_t(8'h00, 1'b0);
    chk_eq("resync_err", s_err, 0);
    cycle_t(8'h01, 1'b0);
    chk_eq("recheck_err", s_err, 1);
    chk_eq("recheck_halted", s_halted, 1);

    // chk_en=0: no errors, shadow keeps tracking
    clr_t(8'h00);
    cycle_t(8'h00, 1'b0);
    chk_en = 1'b0;
    cycle_t(8'h55, 1'b0);
    cycle_t(8'h00, 1'b1);
    chk_eq("chkoff_err", a_err, 0);
    chk_en = 1'b1;
    cycle_t(8'h00, 1'b0);
    cycle_t(8'h00, 1'b0);
    chk_eq("chkoff_err_cnt", a_err_cnt, 0);
    chk_eq("chkoff_valid", a_valid, 0);

    // Saturation after 300 faults
    for (int i = 0; i < 300; i++) begin
      cycle_t(8'h80, 1'b0);
      if (i == 253) chk_eq("sat_fe", a_err_cnt, 8'hFE);
    end
    chk_eq("sat_ff", a_err_cnt, 8'hFF);

    // Async reset mid-run with err_cnt=3
    clr_t(8'h10);
    cycle_t(8'h00, 1'b0);
    for (int i = 0; i < 3; i++) cycle_t(8'h80, 1'b0);
    chk_eq("mid_err_cnt", a_err_cnt, 3);
    #2 reset = 1'b0;
    #1;
    chk_eq("mid_rst_err", a_err, 0);
    chk_eq("mid_rst_err_cnt", a_err_cnt, 0);
    chk_eq("mid_rst_valid", a_valid, 0);
    chk_eq("mid_rst_exp", a_exp, 0);
    chk_eq("mid_rst_act", a_act, 0);
    chk_eq("mid_rst_cyc", a_cyc, 0);
    chk_eq("mid_rst_halted", s_halted, 0);
    @(negedge clk);
    reset = 1'b1;
    cycle_t(8'h00, 1'b0);
    chk_eq("post_rst_count_nz", (count != 8'h00), 1);
    chk_eq("post_rst_err", a_err, 0);
    cycle_t(8'h00, 1'b0);
    chk_eq("post_rst_err2", a_err, 0);
    chk_eq("post_rst_err_cnt", a_err_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
